// File: rtl/fetch_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit_pkg
// Description : Shared types and constants for the instruction-fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_prefetch_unit_pkg;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Redirect targets are forced onto a word boundary; the low bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit_if
// Description : Bus bundle between the fetch unit, instr_mem, EX redirect and
//               the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_prefetch_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_out;
  logic [31:0]      instr_in;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             out_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] occupancy;

  // Fetch unit side.
  modport master (
    output pc_out, out_valid, out_pc, out_instr, occupancy,
    input  instr_in, redirect_valid, redirect_pc, out_ready
  );

  // Environment side (memory, EX stage, decode).
  modport slave (
    input  pc_out, out_valid, out_pc, out_instr, occupancy,
    output instr_in, redirect_valid, redirect_pc, out_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_prefetch_unit_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch entries with flush; push and pop in
//               the same cycle on a full queue both take effect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wr_data,
  output fetch_entry_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("fetch_queue: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Qualify requests against occupancy and compute next pointers/count.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Instruction-fetch front end: drives the fetch address, queues
//               returned instructions and hands them to decode; EX redirects
//               flush the queue and restart fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_prefetch_unit_if.master  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             push, pop, valid;
  logic             q_empty, q_full;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     wr_entry, head;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (q_count),
    .empty   (q_empty),
    .full    (q_full)
  );

  // Redirect outranks everything: it hides the head and blocks the fetch.
  always_comb begin
    valid          = ~bus.redirect_valid & ~q_empty;
    pop            = valid & bus.out_ready;
    push           = ~bus.redirect_valid & (~q_full | pop);
    wr_entry.pc    = fetch_pc_q;
    wr_entry.instr = bus.instr_in;
    fetch_pc_d     = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = align_pc(bus.redirect_pc);
    else if (push)          fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  // Fetch address register; reset also discards a concurrent redirect.
  always_ff @(posedge clk) begin
    if (reset) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  assign bus.pc_out    = fetch_pc_q;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? head.pc    : 32'h0;
  assign bus.out_instr = valid ? head.instr : 32'h0;
  assign bus.occupancy = q_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Self-checking bench: directed vector table, hand-written corner
//               sequences and a randomized run against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if #(.DEPTH(DEPTH)) bus ();

  fetch_prefetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // instr_mem contents: a word-address hash so every location is distinct.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  always_comb bus.instr_in = mem_f(bus.pc_out);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input int eocc, input logic [31:0] epcout);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, " out_pc"},    bus.out_pc,    ev ? epc : 32'h0);
    chk({tag, " out_instr"}, bus.out_instr, ev ? mem_f(epc) : 32'h0);
    chk({tag, " occupancy"}, 32'(bus.occupancy), 32'(eocc));
    chk({tag, " pc_out"},    bus.pc_out,    epcout);
  endtask

  // Reference model: expected queue contents as a list of PCs plus next fetch PC.
  logic [31:0] mq[$];
  logic [31:0] mfetch;

  task automatic model_check(input string tag);
    logic v;
    v = !bus.redirect_valid && (mq.size() > 0);
    chk_out(tag, v, v ? mq[0] : 32'h0, mq.size(), mfetch);
  endtask

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] rpc,
                            input logic rdy);
    logic v, room;
    if (rst) begin
      mq.delete();
      mfetch = RESET_PC;
    end else if (rv) begin
      mq.delete();
      mfetch = rpc & ~32'd3;
    end else begin
      v    = mq.size() > 0;
      room = mq.size() < DEPTH;
      if (v && rdy) void'(mq.pop_front());
      if (room || (v && rdy)) begin
        mq.push_back(mfetch);
        mfetch = mfetch + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    int          eocc;
    logic [31:0] epcout;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Fill from reset, saturate, drain with simultaneous push/pop, misaligned
    // redirect, then redirect to the top of memory and wrap through zero.
    tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1, 32'h4};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         2, 32'h8};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         3, 32'hC};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4, 32'h10};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4, 32'h10};
    tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         4, 32'h10};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         4, 32'h14};
    tbl[8]  = '{1'b1, 32'h23,        1'b0, 1'b0, 32'h0,         4, 32'h18};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0, 32'h20};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h20,        1, 32'h24};
    tbl[11] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0,         1, 32'h28};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0, 32'hFFFF_FFF8};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC};
    tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1, 32'h0};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1, 32'h4};

    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 0, RESET_PC);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset              = 1'b0;
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc    = tbl[i].rpc;
      bus.out_ready      = tbl[i].rdy;
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eocc, tbl[i].epcout);
    end

    // Reset while full and with a redirect pending: both are discarded.
    @(negedge clk);
    reset = 1'b1; bus.redirect_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("full before reset occupancy", 32'(bus.occupancy), 32'(DEPTH));
    reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    @(negedge clk);
    reset = 1'b0; bus.redirect_valid = 1'b0;
    #1;
    chk_out("reset+redirect", 1'b0, 32'h0, 0, RESET_PC);

    // Back-to-back redirects: the later target wins.
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    @(negedge clk);
    bus.redirect_pc = 32'h200;
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk_out("b2b redirect", 1'b0, 32'h0, 0, 32'h200);
    @(negedge clk);
    #1;
    chk_out("b2b target", 1'b1, 32'h200, 1, 32'h204);

    // Randomized run against the model.
    @(negedge clk);
    reset = 1'b1; bus.redirect_valid = 1'b0; bus.out_ready = 1'b0;
    model_step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      reset              = ($urandom_range(0, 99) == 0);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0)
                           ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                           : 32'($urandom);
      bus.out_ready      = (c % 100 < 40) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
      #1;
      model_check($sformatf("rand%0d", c));
      model_step(reset, bus.redirect_valid, bus.redirect_pc, bus.out_ready);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end of the 5-stage core; sits between instr_mem and the IF/ID pipeline register.
- Drives the fetch address, captures the combinational instr_mem read into a small prefetch queue, and presents {pc, instr} to decode under a valid/ready handshake.
- Taken jumps and branches are resolved in EX. A redirect from EX flushes the queue and restarts fetch at the target address.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.
- DEPTH, 4: prefetch queue entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous reset, active-high.
- pc_out  out  32  fetch address to instr_mem.addr.
- instr_in  in  32  instr_mem.instr; combinational read of pc_out in the same cycle.
- redirect_valid  in  1  EX taken jump/branch.
- redirect_pc  in  32  jump/branch target.
- out_ready  in  1  IF/ID can accept (driven as ~stall by the hazard unit).
- out_valid  out  1  head entry valid.
- out_pc  out  32  PC of head entry.
- out_instr  out  32  instruction of head entry.
- occupancy  out  $clog2(DEPTH+1)  queue entry count.

Behaviour:
- Reset (synchronous, sampled on the clk rising edge):
  - fetch_pc <= RESET_PC; count, rd_ptr and wr_ptr <= 0.
  - Outputs after reset: out_valid=0, pc_out=RESET_PC, occupancy=0.
  - out_pc and out_instr are driven 0 while out_valid=0.
  - A reset asserted mid-operation discards all queued entries and any concurrent redirect.
- pc_out = fetch_pc (registered), never combinational from redirect_pc.
- pop = out_valid & out_ready.
- push = ~redirect_valid & (count < DEPTH | pop).
- A push writes {fetch_pc, instr_in} at wr_ptr and advances fetch_pc by 4.
- Arithmetic: fetch_pc + 4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). Pointers wrap modulo DEPTH.
- Full queue with pop in the same cycle: push and pop both occur and count is unchanged.
- Full queue without pop: no push and fetch_pc holds.
- Empty queue: out_valid=0, so no pop occurs. Push-to-output latency is 1 cycle; the first instruction after reset is valid on the first edge after reset falls.
- Redirect has highest priority:
  - Same cycle: out_valid is forced to 0, so no pop occurs regardless of out_ready.
  - Next edge: count, rd_ptr and wr_ptr <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}. The low 2 bits are silently cleared.
  - The target instruction is pushed in the cycle after the redirect and is valid at the output 2 edges after the redirect cycle.
- Redirect asserted together with out_ready=0: flush still occurs.
- Back-to-back redirects: the last one wins.
- Outputs out_pc, out_instr and out_valid come from the queue head. They are stable while out_valid=1 and out_ready=0.

Decomposition:
- Add to control_types_pkg:
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}.
  - NOP_INSTR = 32'h0000_0013.
- Sub-module fetch_queue: generic synchronous FIFO of fetch_entry_t with a DEPTH parameter, push/pop/flush inputs, count output, and defined simultaneous push+pop when full.
- Top level holds fetch_pc, the redirect priority logic and the handshake.

Test Plan:
- Reset release, out_ready=1 held, instr_mem loaded with addi sequence -> out_pc sequence 0,4,8,C on consecutive cycles starting 1 cycle after reset; occupancy never exceeds 1.
- out_ready=0 for 10 cycles after reset -> occupancy saturates at 4, pc_out holds 32'h10, head stays pc=0. Then out_ready=1 -> pcs 0,4,8,C,10 emitted in order with no gaps.
- Queue holding pcs 8..14 plus redirect_valid=1, redirect_pc=32'h40 -> out_valid=0 that cycle, occupancy=0 next cycle, next emitted out_pc=32'h40 with instr_mem[0x40>>2]; no pc 8..14 ever emitted after the redirect.
- redirect_pc=32'h0000_0023 -> fetch resumes at 32'h20.
- Redirect to 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted with queue full and a redirect pending -> next cycle out_valid=0, occupancy=0, pc_out=RESET_PC.
- Same-cycle push and pop with the queue full -> occupancy stays 4 and order is preserved.
